// File: rtl/alu_shift_issue_if.sv
// rtl/alu_shift_issue_if.sv - instruction/result handshake and datapath bus of the ALU/shift issue controller
interface alu_shift_issue_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_rs_val;
  logic [DW-1:0] in_rt_val;
  logic [DW-1:0] dp_rs;
  logic [DW-1:0] dp_rt;
  logic [2:0]    dp_opcode;
  logic [1:0]    dp_sel;
  logic [DW-1:0] dp_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [4:0]    out_rd;
  logic          out_err;

  // slave is the issue controller; master is the instruction source, datapath and result consumer
  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, dp_result, out_ready,
    output in_ready, dp_rs, dp_rt, dp_opcode, dp_sel, out_valid, out_result, out_rd, out_err
  );

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, dp_result, out_ready,
    input  in_ready, dp_rs, dp_rt, dp_opcode, dp_sel, out_valid, out_result, out_rd, out_err
  );
endinterface

// File: rtl/alu_shift_issue.sv
// rtl/alu_shift_issue.sv - decodes R-type ops onto shifterAndAlu and returns the captured result
module alu_shift_issue #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_shift_issue_if.slave bus,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [5:0]    opField;
  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic [2:0]    decOp;
  logic [1:0]    decSel;
  logic [DW-1:0] decRs;
  logic [DW-1:0] decRt;
  logic          decIll;
  logic          isShift;

  assign opField = bus.in_instr[31:26];
  assign funct   = bus.in_instr[5:0];
  assign shamt   = bus.in_instr[10:6];

  always_comb begin
    decOp   = 3'd0;
    decSel  = 2'b00;
    decIll  = 1'b0;
    isShift = 1'b0;
    decRs   = '0;
    decRt   = '0;
    case (funct)
      6'h20: begin decOp = 3'd1; decSel = 2'b01; end
      6'h22: begin decOp = 3'd2; decSel = 2'b01; end
      6'h24: begin decOp = 3'd3; decSel = 2'b01; end
      6'h25: begin decOp = 3'd4; decSel = 2'b01; end
      6'h27: begin decOp = 3'd5; decSel = 2'b01; end
      6'h03: begin decOp = 3'd1; decSel = 2'b10; isShift = 1'b1; end
      6'h02: begin decOp = 3'd2; decSel = 2'b11; isShift = 1'b1; end
      6'h06: begin decOp = 3'd3; decSel = 2'b11; isShift = 1'b1; end
      6'h00: begin decOp = 3'd4; decSel = 2'b11; isShift = 1'b1; end
      6'h04: begin decOp = 3'd5; decSel = 2'b11; isShift = 1'b1; end
      default: decIll = 1'b1;
    endcase
    // the shifter only takes a 3-bit amount, so shamt 8..31 cannot be honoured
    if (opField != 6'h00 || (isShift && shamt[4:3] != 2'b00)) begin
      decIll = 1'b1;
    end
    decRs = isShift ? bus.in_rt_val : bus.in_rs_val;
    decRt = isShift ? {{(DW-3){1'b0}}, shamt[2:0]} : bus.in_rt_val;
    if (decIll) begin
      decOp  = 3'd0;
      decSel = 2'b00;
      decRs  = '0;
      decRt  = '0;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.dp_rs      <= '0;
      bus.dp_rt      <= '0;
      bus.dp_opcode  <= 3'd0;
      bus.dp_sel     <= 2'b00;
      bus.out_result <= '0;
      bus.out_rd     <= 5'd0;
      bus.out_err    <= 1'b0;
      op_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.dp_rs     <= decRs;
            bus.dp_rt     <= decRt;
            bus.dp_opcode <= decOp;
            bus.dp_sel    <= decSel;
            bus.out_rd    <= bus.in_instr[15:11];
            bus.out_err   <= decIll;
            state         <= EXEC;
          end
        end
        EXEC: begin
          bus.out_result <= bus.out_err ? '0 : bus.dp_result;
          state          <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            op_count <= op_count + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_shift_issue.sv
// tb/tb_alu_shift_issue.sv - scoreboard bench for alu_shift_issue with a behavioural shifterAndAlu
module tb_alu_shift_issue;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset2;
  logic [15:0] opCount;
  logic [1:0]  opCount2;
  logic [15:0] expCount;
  int          passCnt = 0;
  int          totalCnt = 0;
  int          wrapCnt = 0;
  exp_t        sbQ[$];
  logic [7:0]  shV;
  logic [7:0]  shR;
  int          shAmt;

  always #5 clk = ~clk;

  alu_shift_issue_if #(.DW(32)) bus ();
  alu_shift_issue_if #(.DW(32)) bus2 ();

  alu_shift_issue #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .op_count(opCount)
  );

  alu_shift_issue #(.DW(32), .CNT_W(2)) dutWrap (
    .clk(clk), .reset(reset2), .bus(bus2), .op_count(opCount2)
  );

  // behavioural shifterAndAlu: shifter works on the low byte only
  always_comb begin
    shV           = bus.dp_rs[7:0];
    shAmt         = int'(bus.dp_rt[2:0]);
    shR           = 8'h00;
    bus.dp_result = '0;
    case (bus.dp_opcode)
      3'd1: shR = $signed(shV) >>> shAmt;
      3'd2: shR = shV >> shAmt;
      3'd3: shR = (shV >> shAmt) | (shV << (8 - shAmt));
      3'd4: shR = shV << shAmt;
      3'd5: shR = (shV << shAmt) | (shV >> (8 - shAmt));
      default: shR = 8'h00;
    endcase
    case (bus.dp_sel)
      2'b01: begin
        case (bus.dp_opcode)
          3'd1: bus.dp_result = bus.dp_rs + bus.dp_rt;
          3'd2: bus.dp_result = bus.dp_rs - bus.dp_rt;
          3'd3: bus.dp_result = bus.dp_rs & bus.dp_rt;
          3'd4: bus.dp_result = bus.dp_rs | bus.dp_rt;
          3'd5: bus.dp_result = ~bus.dp_rs;
          default: bus.dp_result = '0;
        endcase
      end
      2'b10: bus.dp_result = {{24{shR[7]}}, shR};
      2'b11: bus.dp_result = {24'h000000, shR};
      default: bus.dp_result = '0;
    endcase
  end

  assign bus2.dp_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] shamt, input logic [5:0] funct);
    return {op, 10'd0, rd, shamt, funct};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbQ.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_result actual=%h required=none", bus.out_result);
      end else begin
        e = sbQ.pop_front();
        check("result", bus.out_result, e.res);
        check("rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
        check("err", {31'd0, bus.out_err}, {31'd0, e.err});
        expCount = expCount + 16'd1;
      end
    end
    if (!reset2 && bus2.out_valid && bus2.out_ready) wrapCnt++;
  end

  // leaves the bench at accept edge + 1 (controller in EXEC)
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] expRes, input logic expErr, input bit push);
    int n;
    if (push) sbQ.push_back('{expRes, instr[15:11], expErr});
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = $urandom;
    bus.in_rs_val = $urandom;
    bus.in_rt_val = $urandom;
    check("exec_no_valid", {31'd0, bus.out_valid}, 32'd0);
    check("exec_not_ready", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic runOp(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] expRes, input logic expErr);
    issue(instr, rs, rt, expRes, expErr, 1'b1);
    @(posedge clk); #1;
    check("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] heldRes;
    bit saw3;
    reset = 1'b1;
    reset2 = 1'b1;
    expCount = 16'd0;
    bus.in_valid = 1'b0;   bus.in_instr = '0;  bus.in_rs_val = '0;  bus.in_rt_val = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0;  bus2.in_instr = '0; bus2.in_rs_val = '0; bus2.in_rt_val = '0;
    bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    reset2 = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("rst_dp_rs", bus.dp_rs, 32'd0);
    check("rst_dp_ctl", {27'd0, bus.dp_opcode, bus.dp_sel}, 32'd0);
    check("rst_op_count", {16'd0, opCount}, 32'd0);

    // 2-bit counter instance: sll-by-0 ops back to back, counter must wrap 3 -> 0
    bus2.in_valid = 1'b1;
    saw3 = 1'b0;
    for (int i = 0; i < 40 && wrapCnt < 4; i++) begin
      @(posedge clk); #1;
      if (wrapCnt == 3 && !saw3) begin
        check("wrap_count_three", {30'd0, opCount2}, 32'd3);
        saw3 = 1'b1;
      end
    end
    bus2.in_valid = 1'b0;
    check("wrap_handoffs", wrapCnt, 32'd4);
    check("wrap_to_zero", {30'd0, opCount2}, 32'd0);

    runOp(mk(6'h00, 5'd5,  5'd0, 6'h20), 32'd17,        32'd3,        32'd20,        1'b0);
    runOp(mk(6'h00, 5'd6,  5'd0, 6'h22), 32'd17,        32'd3,        32'd14,        1'b0);
    runOp(mk(6'h00, 5'd7,  5'd0, 6'h24), 32'h0000F0F0,  32'h0000FF00, 32'h0000F000,  1'b0);
    runOp(mk(6'h00, 5'd8,  5'd0, 6'h25), 32'h0000F0F0,  32'h0000FF00, 32'h0000FFF0,  1'b0);
    runOp(mk(6'h00, 5'd10, 5'd0, 6'h27), 32'h0000FFFF,  32'h00001234, 32'hFFFF0000,  1'b0);
    runOp(mk(6'h00, 5'd11, 5'd1, 6'h03), 32'h0000DEAD,  32'h00000080, 32'hFFFFFFC0,  1'b0);
    runOp(mk(6'h00, 5'd12, 5'd1, 6'h02), 32'h0000DEAD,  32'h00000080, 32'h00000040,  1'b0);
    runOp(mk(6'h00, 5'd13, 5'd1, 6'h00), 32'h0000DEAD,  32'h00000080, 32'h00000000,  1'b0);
    runOp(mk(6'h00, 5'd14, 5'd1, 6'h04), 32'h0000DEAD,  32'h00000081, 32'h00000003,  1'b0);
    runOp(mk(6'h00, 5'd15, 5'd1, 6'h06), 32'h0000DEAD,  32'h00000081, 32'h000000C0,  1'b0);
    runOp(mk(6'h00, 5'd16, 5'd7, 6'h00), 32'h0000DEAD,  32'h00000001, 32'h00000080,  1'b0);
    runOp(mk(6'h00, 5'd17, 5'd3, 6'h03), 32'h0000DEAD,  32'h0000007F, 32'h0000000F,  1'b0);
    runOp(mk(6'h00, 5'd18, 5'd0, 6'h3F), 32'd17,        32'd3,        32'd0,         1'b1);
    runOp(mk(6'h00, 5'd19, 5'd9, 6'h00), 32'h0000DEAD,  32'h00000080, 32'd0,         1'b1);
    runOp(mk(6'h08, 5'd20, 5'd0, 6'h20), 32'd17,        32'd3,        32'd0,         1'b1);
    runOp(mk(6'h00, 5'd21, 5'd0, 6'h20), 32'd1,         32'd1,        32'd2,         1'b0);
    check("count_after_directed", {16'd0, opCount}, {16'd0, expCount});

    // backpressure: result held for 5 cycles with the counter frozen
    bus.out_ready = 1'b0;
    runOp(mk(6'h00, 5'd9, 5'd0, 6'h20), 32'd100, 32'd23, 32'd123, 1'b0);
    heldRes = bus.out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_result", bus.out_result, heldRes);
      check("bp_rd", {27'd0, bus.out_rd}, 32'd9);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_count", {16'd0, opCount}, {16'd0, expCount});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_count_after", {16'd0, opCount}, {16'd0, expCount});
    check("bp_back_idle", {31'd0, bus.in_ready}, 32'd1);

    // reset while in EXEC discards the op
    issue(mk(6'h00, 5'd22, 5'd0, 6'h20), 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
    reset = 1'b1;
    expCount = 16'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_op_count", {16'd0, opCount}, 32'd0);
    check("mid_rst_result", bus.out_result, 32'd0);
    check("mid_rst_rd_err", {26'd0, bus.out_rd, bus.out_err}, 32'd0);
    check("mid_rst_dp_sel", {30'd0, bus.dp_sel}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_no_output", {31'd0, bus.out_valid}, 32'd0);

    runOp(mk(6'h00, 5'd1, 5'd0, 6'h20), 32'd1, 32'd2, 32'd3, 1'b0);
    runOp(mk(6'h00, 5'd2, 5'd2, 6'h02), 32'd0, 32'h000000F0, 32'h0000003C, 1'b0);
    runOp(mk(6'h00, 5'd3, 5'd0, 6'h25), 32'h00000001, 32'h00000100, 32'h00000101, 1'b0);
    check("count_three", {16'd0, opCount}, 32'd3);

    check("sb_empty", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
